step_controller: RTL
====================

STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter: RATE_DIV, default 1000000, cycles between consecutive step pulses in burst/run modes (100 Hz at 100 MHz); legal range 2..2^27-1.
REQ-002 iwClk100M  in  1  sole clock, rising edge; all state updates on this edge.
REQ-003 iwRst  in  1  synchronous, active-high reset.
REQ-004 iwKeyPulse  in  1  one-cycle pulse per debounced key press.
REQ-005 iwMode  in  2  00 single-step, 01 burst, 10 free-run, 11 run-to-breakpoint.
REQ-006 iwBurstLen  in  8  number of steps issued in burst mode.
REQ-007 iwPc  in  32  current CPU program counter.
REQ-008 iwBreakPc  in  32  breakpoint address for mode 11.
REQ-009 owStepEn  out  1  one-cycle CPU clock-enable pulse; one pulse = one CPU step.
REQ-010 owRunning  out  1  high while in BURST or RUN state.
REQ-011 owStepCount  out  16  total pulses issued since reset.
REQ-012 owBreakHit  out  1  sticky flag; breakpoint reached in mode 11.

Function
REQ-013 FSM states: IDLE, STEP, BURST, RUN; all registered, one-hot or binary at implementer's choice.
REQ-014 IDLE + iwKeyPulse: iwMode and iwBurstLen latched that cycle; owBreakHit cleared; next state per latched mode: 00->STEP, 01->BURST, 10/11->RUN.
REQ-015 STEP: owStepEn high for exactly one cycle (cycle after key press), then IDLE.
REQ-016 BURST/RUN: first pulse issued cycle after key press; subsequent pulses every RATE_DIV cycles, timed by a divider counter cleared on entry.
REQ-017 BURST: remaining count loaded from latched iwBurstLen; decremented per pulse; IDLE when it reaches 0 after its last pulse; iwBurstLen = 0 -> no pulse, BURST exits to IDLE the next cycle.
REQ-018 RUN with latched mode 11: at each pulse slot, if iwPc == iwBreakPc, no pulse issued, owBreakHit set, next state IDLE; otherwise pulse issued.
REQ-019 RUN with latched mode 10: runs indefinitely until abort.
REQ-020 iwKeyPulse in BURST or RUN: abort; next state IDLE; no pulse that cycle even if a pulse slot coincides (key wins).
REQ-021 iwMode/iwBurstLen changes while not IDLE: ignored until next start.
REQ-022 iwKeyPulse in STEP: ignored.
REQ-023 owStepCount increments by 1 on every owStepEn cycle; wraps 0xFFFF->0x0000.
REQ-024 owStepEn never high in two consecutive cycles except when RATE_DIV pulse spacing allows (never, given RATE_DIV >= 2).
REQ-025 owRunning registered, high exactly when state is BURST or RUN.
REQ-026 owBreakHit only set by REQ-018; holds through IDLE until next start or reset.

Reset
REQ-027 iwRst high at a clock edge: state IDLE, divider and remaining count 0, owStepEn 0, owRunning 0, owStepCount 0, owBreakHit 0 next cycle.
REQ-028 Reset mid-BURST/RUN aborts immediately; no pulse in the reset cycle; iwKeyPulse during reset ignored.

Verification (RATE_DIV overridden to 4)
REQ-029 Mode 00, key pulse at cycle N -> owStepEn high only at N+1; owStepCount = 1; owRunning stays 0.
REQ-030 Mode 01, iwBurstLen = 3, key at N -> pulses at N+1, N+5, N+9; IDLE by N+10; owStepCount = 3; iwBurstLen = 0 -> no pulses, owRunning 0 by N+2.
REQ-031 Mode 11, iwBreakPc = 0x10, iwPc advanced by 4 per pulse from 0x0 -> 4 pulses (PC 0,4,8,C), at slot with PC 0x10 no pulse, owBreakHit = 1, owRunning = 0.
REQ-032 Mode 10, second key pulse coinciding with a pulse slot -> no pulse that cycle, IDLE next cycle, owStepCount unchanged.
REQ-033 owStepCount preloaded to 0xFFFF via 65535 steps, one more step -> 0x0000; iwRst asserted mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/step_controller.sv
// Step controller for single-stepping a soft CPU.
// Issues one-cycle clock-enable pulses in single-step, burst, free-run or
// run-to-breakpoint modes. It counts every pulse issued and keeps a sticky
// flag that records when the breakpoint stopped a run.
module step_controller #(
  parameter int RATE_DIV = 1000000
) (
  input  logic        iwClk100M,
  input  logic        iwRst,
  input  logic        iwKeyPulse,
  input  logic [1:0]  iwMode,
  input  logic [7:0]  iwBurstLen,
  input  logic [31:0] iwPc,
  input  logic [31:0] iwBreakPc,
  output logic        owStepEn,
  output logic        owRunning,
  output logic [15:0] owStepCount,
  output logic        owBreakHit
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STEP  = 2'b01,
    BURST = 2'b10,
    RUN   = 2'b11
  } stateT;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_FREE   = 2'b10;
  localparam logic [1:0] MODE_BREAK  = 2'b11;

  // The divider resets to 0 on the cycle after each pulse slot. It therefore
  // reaches RATE_DIV-1 exactly RATE_DIV cycles after the previous slot.
  localparam logic [26:0] DIV_LAST = 27'(RATE_DIV - 1);

  stateT       state;
  stateT       stateNext;
  logic [1:0]  latchedMode;
  logic [1:0]  modeNext;
  logic [7:0]  remaining;
  logic [7:0]  remainingNext;
  logic [26:0] divider;
  logic [26:0] dividerNext;
  logic        stepEnNext;
  logic        runningNext;
  logic        breakHitNext;
  logic [15:0] stepCount;
  logic        slot;

  assign slot        = (divider == DIV_LAST);
  assign owStepCount = stepCount;

  // Next-state logic. All outputs are registered, so each pulse is decided
  // one edge before the cycle in which it appears.
  always_comb begin
    stateNext     = state;
    modeNext      = latchedMode;
    remainingNext = remaining;
    dividerNext   = divider;
    stepEnNext    = 1'b0;
    breakHitNext  = owBreakHit;
    runningNext   = 1'b0;

    case (state)
      IDLE: begin
        if (iwKeyPulse) begin
          modeNext      = iwMode;
          breakHitNext  = 1'b0;
          dividerNext   = '0;
          remainingNext = '0;
          case (iwMode)
            MODE_SINGLE: begin
              stateNext  = STEP;
              stepEnNext = 1'b1;
            end
            MODE_BURST: begin
              stateNext = BURST;
              if (iwBurstLen != 8'd0) begin
                stepEnNext    = 1'b1;
                remainingNext = iwBurstLen - 8'd1;
              end
            end
            MODE_FREE: begin
              stateNext  = RUN;
              stepEnNext = 1'b1;
            end
            MODE_BREAK: begin
              // The start edge is itself a pulse slot, so a PC that is
              // already at the breakpoint stops the run immediately.
              if (iwPc == iwBreakPc) begin
                breakHitNext = 1'b1;
              end else begin
                stateNext  = RUN;
                stepEnNext = 1'b1;
              end
            end
          endcase
        end
      end

      STEP: begin
        stateNext = IDLE;
      end

      BURST: begin
        if (iwKeyPulse) begin
          stateNext = IDLE;
        end else if (remaining == 8'd0) begin
          stateNext = IDLE;
        end else if (slot) begin
          dividerNext   = '0;
          stepEnNext    = 1'b1;
          remainingNext = remaining - 8'd1;
        end else begin
          dividerNext = divider + 27'd1;
        end
      end

      RUN: begin
        if (iwKeyPulse) begin
          stateNext = IDLE;
        end else if (slot) begin
          dividerNext = '0;
          if ((latchedMode == MODE_BREAK) && (iwPc == iwBreakPc)) begin
            breakHitNext = 1'b1;
            stateNext    = IDLE;
          end else begin
            stepEnNext = 1'b1;
          end
        end else begin
          dividerNext = divider + 27'd1;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (stateNext == IDLE) begin
      dividerNext   = '0;
      remainingNext = '0;
    end

    runningNext = (stateNext == BURST) || (stateNext == RUN);
  end

  // State, timing and output registers. The step counter adds one at the end
  // of every cycle in which the enable pulse is high.
  always_ff @(posedge iwClk100M) begin
    if (iwRst) begin
      state       <= IDLE;
      latchedMode <= MODE_SINGLE;
      remaining   <= '0;
      divider     <= '0;
      owStepEn    <= 1'b0;
      owRunning   <= 1'b0;
      owBreakHit  <= 1'b0;
      stepCount   <= '0;
    end else begin
      state       <= stateNext;
      latchedMode <= modeNext;
      remaining   <= remainingNext;
      divider     <= dividerNext;
      owStepEn    <= stepEnNext;
      owRunning   <= runningNext;
      owBreakHit  <= breakHitNext;
      stepCount   <= stepCount + {15'd0, owStepEn};
    end
  end

endmodule
